// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative ASCON substitution layer:
// permutation state type, 5-bit S-box table and the layer FSM encoding.
package ascon_pack;

  // Five 64-bit words x0..x4; x0 is element 0.
  typedef logic [0:4][63:0] type_state;

  // ASCON S-box, entry n is the substitution of input value n (x0 is bit 4).
  localparam logic [0:31][4:0] SBOX_LUT = {
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  // Layer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_fsm;

  // Single-column substitution through the table.
  function automatic logic [4:0] sbox_lookup(input logic [4:0] col);
    return SBOX_LUT[col];
  endfunction

endpackage

// File: rtl/ascon_sub_layer_sbox.sv
// One 5-bit ASCON S-box cell: purely combinational table lookup.
// The input column is {x0,x1,x2,x3,x4} with x0 in bit 4.
module ascon_sub_layer_sbox
  import ascon_pack::*;
(
  input  logic [4:0] col_i,
  output logic [4:0] col_o
);

  // Table lookup of one column.
  always_comb begin
    col_o = sbox_lookup(col_i);
  end

endmodule

// File: rtl/ascon_sub_layer.sv
// Iterative ASCON substitution layer. NB_SBOX columns of the 320-bit state
// are substituted per clock, K = 64/NB_SBOX cycles per state, in place in an
// internal state register, with a start/ready/valid handshake.
// Optional build macro ASCON_SUB_PIPE_EN inserts a register between the
// slice read (S-box output) and the write-back, adding one cycle of latency.
module ascon_sub_layer
  import ascon_pack::*;
#(
  parameter int NB_SBOX = 8
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state state_i,
  output logic      ready_o,
  output logic      valid_o,
  output type_state state_o
);

  localparam int K     = 64 / NB_SBOX;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Only power-of-two widths that divide the 64 columns are meaningful.
  generate
    if (!((NB_SBOX == 1) || (NB_SBOX == 2) || (NB_SBOX == 4) || (NB_SBOX == 8) ||
          (NB_SBOX == 16) || (NB_SBOX == 32) || (NB_SBOX == 64))) begin : g_bad_nb_sbox
      $error("ascon_sub_layer: NB_SBOX must be one of 1,2,4,8,16,32,64");
    end
  endgenerate

  type_fsm              fsm_q, fsm_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  type_state            state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;

  logic [5:0]           rd_base_s;
  logic [5:0]           wr_base_s;
  logic [0:4][NB_SBOX-1:0] rd_slice_s;
  logic [0:4][NB_SBOX-1:0] sub_slice_s;
  logic [0:4][NB_SBOX-1:0] wr_slice_s;
  logic [CNT_W-1:0]     wr_idx_s;
  logic                 wr_en_s;
  logic                 last_wr_s;
  logic [4:0]           col_in_s  [NB_SBOX];
  logic [4:0]           col_out_s [NB_SBOX];

  // Select the slice addressed by the column counter.
  always_comb begin
    rd_base_s = 6'(int'(cnt_q) * NB_SBOX);
    for (int r = 0; r < 5; r++) begin
      rd_slice_s[r] = state_q[r][rd_base_s +: NB_SBOX];
    end
  end

  generate
    for (genvar i = 0; i < NB_SBOX; i++) begin : g_sbox
      assign col_in_s[i] = {rd_slice_s[0][i], rd_slice_s[1][i], rd_slice_s[2][i],
                            rd_slice_s[3][i], rd_slice_s[4][i]};
      ascon_sub_layer_sbox u_sbox (
        .col_i (col_in_s[i]),
        .col_o (col_out_s[i])
      );
    end
  endgenerate

  // Scatter each substituted column back into the five row slices.
  always_comb begin
    sub_slice_s = '0;
    for (int i = 0; i < NB_SBOX; i++) begin
      sub_slice_s[0][i] = col_out_s[i][4];
      sub_slice_s[1][i] = col_out_s[i][3];
      sub_slice_s[2][i] = col_out_s[i][2];
      sub_slice_s[3][i] = col_out_s[i][1];
      sub_slice_s[4][i] = col_out_s[i][0];
    end
  end

`ifdef ASCON_SUB_PIPE_EN
  logic                    pipe_vld_q, pipe_vld_d;
  logic [CNT_W-1:0]        pipe_idx_q, pipe_idx_d;
  logic [0:4][NB_SBOX-1:0] pipe_q, pipe_d;

  // Write-back comes from the pipeline register, one cycle behind the read.
  always_comb begin
    wr_slice_s = pipe_q;
    wr_idx_s   = pipe_idx_q;
    wr_en_s    = pipe_vld_q && (fsm_q == RUN);
    last_wr_s  = wr_en_s && (pipe_idx_q == CNT_LAST);
  end

  // Capture the current read slice; the flag drops once the last slice lands.
  always_comb begin
    pipe_d     = sub_slice_s;
    pipe_idx_d = cnt_q;
    if (fsm_q == RUN) begin
      pipe_vld_d = !last_wr_s;
    end else begin
      pipe_vld_d = 1'b0;
    end
  end

  // Pipeline register between S-box output and state write-back.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      pipe_q     <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      pipe_q     <= pipe_d;
    end
  end
`else
  // Write-back goes straight to the slice that was just read.
  always_comb begin
    wr_slice_s = sub_slice_s;
    wr_idx_s   = cnt_q;
    wr_en_s    = (fsm_q == RUN);
    last_wr_s  = wr_en_s && (cnt_q == CNT_LAST);
  end
`endif

  // Next-state, counter and in-place state update.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    wr_base_s = 6'(int'(wr_idx_s) * NB_SBOX);
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          cnt_d   = '0;
          fsm_d   = RUN;
        end else begin
          fsm_d   = IDLE;
        end
      end
      RUN: begin
        // Guarded increment keeps the slice index inside the 64 columns.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (wr_en_s) begin
          for (int r = 0; r < 5; r++) begin
            state_d[r][wr_base_s +: NB_SBOX] = wr_slice_s[r];
          end
        end else begin
          state_d = state_q;
        end
        if (last_wr_s) begin
          fsm_d = DONE;
        end else begin
          fsm_d = RUN;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
    ready_d = (fsm_d == IDLE);
    valid_d = (fsm_d == DONE);
  end

  // Control, counter, state and handshake registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_sub_layer.sv
// Bench for ascon_sub_layer: three instances (NB_SBOX = 8, 1, 64) on one
// clock and reset, a bit-sliced boolean reference model feeding a queue of
// expected states, and directed steps in a single initial block.
module tb_ascon_sub_layer;
  import ascon_pack::*;

`ifdef ASCON_SUB_PIPE_EN
  localparam int PIPE_X = 1;
`else
  localparam int PIPE_X = 0;
`endif

  logic      clk = 1'b0;
  logic      resetb;
  logic      start_s  [3];
  type_state st_in    [3];
  logic      ready_s  [3];
  logic      valid_s  [3];
  type_state st_out   [3];

  int        n_vec = 0;
  int        n_err = 0;
  type_state exp_q [$];

  always #5 clk = ~clk;

  ascon_sub_layer #(.NB_SBOX(8)) u_nb8 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_s[0]), .state_i(st_in[0]),
    .ready_o(ready_s[0]), .valid_o(valid_s[0]), .state_o(st_out[0]));
  ascon_sub_layer #(.NB_SBOX(1)) u_nb1 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_s[1]), .state_i(st_in[1]),
    .ready_o(ready_s[1]), .valid_o(valid_s[1]), .state_o(st_out[1]));
  ascon_sub_layer #(.NB_SBOX(64)) u_nb64 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_s[2]), .state_i(st_in[2]),
    .ready_o(ready_s[2]), .valid_o(valid_s[2]), .state_o(st_out[2]));

  function automatic int k_of(input int w);
    case (w)
      0: return 8;
      1: return 64;
      default: return 1;
    endcase
  endfunction

  // ASCON S-box as boolean equations on whole 64-bit words.
  function automatic type_state ref_sub(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  // Column j takes value (j+off) mod 32, so all 32 inputs appear twice.
  function automatic type_state cover_state(input int off);
    type_state s;
    logic [4:0] c;
    s = '0;
    for (int j = 0; j < 64; j++) begin
      c = 5'((j + off) % 32);
      s[0][j] = c[4]; s[1][j] = c[3]; s[2][j] = c[2]; s[3][j] = c[1]; s[4][j] = c[0];
    end
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int r = 0; r < 5; r++) s[r] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check ready, push the expected result, pulse start across one edge.
  task automatic do_start(input int w, input type_state st);
    chk("ready_before_start", 320'(ready_s[w]), 320'(1));
    st_in[w]   = st;
    start_s[w] = 1'b1;
    exp_q.push_back(ref_sub(st));
    @(posedge clk); #1;
    start_s[w] = 1'b0;
    st_in[w]   = ~st;
  endtask

  task automatic wait_valid(input int w, output int n);
    n = 0;
    while (!valid_s[w] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Latency, result against the scoreboard, then return to idle.
  task automatic finish_txn(input string tag, input int w, input int edges);
    type_state e;
    chk({tag, "_latency"}, 320'(edges + 1), 320'(k_of(w) + 1 + PIPE_X));
    e = exp_q.pop_front();
    chk({tag, "_state"}, st_out[w], e);
    @(posedge clk); #1;
    chk({tag, "_idle"}, 320'({valid_s[w], ready_s[w]}), 320'(2'b01));
  endtask

  task automatic count_valid(input int w, input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (valid_s[w]) cnt++;
    end
  endtask

  initial begin
    int n, pre, pulses;
    type_state a, b;
    resetb = 1'b0;
    for (int w = 0; w < 3; w++) begin
      start_s[w] = 1'b0;
      st_in[w]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      chk("reset_ready", 320'(ready_s[w]), 320'(1));
      chk("reset_valid", 320'(valid_s[w]), 320'(0));
      chk("reset_state", st_out[w], '0);
    end
    resetb = 1'b1;
    @(posedge clk); #1;

    // NB_SBOX=8: all zero and all ones against fixed constants.
    do_start(0, '0);
    wait_valid(0, n);
    chk("zero_const", st_out[0], {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0});
    finish_txn("nb8_zero", 0, n);
    do_start(0, '1);
    wait_valid(0, n);
    chk("ones_const", st_out[0], {64'hFFFFFFFFFFFFFFFF, 64'h0, {3{64'hFFFFFFFFFFFFFFFF}}});
    finish_txn("nb8_ones", 0, n);
    do_start(0, rand_state());
    wait_valid(0, n);
    finish_txn("nb8_rand", 0, n);

    // NB_SBOX=1 and 64: full column coverage plus random states.
    for (int w = 1; w < 3; w++) begin
      do_start(w, cover_state(int'($urandom_range(0, 31))));
      wait_valid(w, n);
      finish_txn("cover", w, n);
      do_start(w, rand_state());
      wait_valid(w, n);
      finish_txn("rand", w, n);
    end

    // Start re-asserted mid-RUN with another state is ignored.
    a = rand_state();
    b = rand_state();
    do_start(0, a);
    repeat (2) @(posedge clk);
    #1;
    st_in[0]   = b;
    start_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    pre = 5;
    wait_valid(0, n);
    finish_txn("restart_ignored", 0, pre + n);
    count_valid(0, 12, pulses);
    chk("restart_one_pulse", 320'(pulses), 320'(0));

    // Reset in cycle 4 of RUN discards the partial result.
    do_start(0, rand_state());
    void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    chk("midrun_rst_state", st_out[0], '0);
    chk("midrun_rst_hs", 320'({valid_s[0], ready_s[0]}), 320'(2'b01));
    @(posedge clk); #1;
    resetb = 1'b1;
    count_valid(0, 12, pulses);
    chk("midrun_no_valid", 320'(pulses), 320'(0));
    do_start(0, rand_state());
    wait_valid(0, n);
    finish_txn("after_reset", 0, n);

    // Start held during the valid cycle is taken in the following idle cycle.
    a = rand_state();
    b = rand_state();
    do_start(2, a);
    wait_valid(2, n);
    chk("held_a_state", st_out[2], exp_q.pop_front());
    st_in[2]   = b;
    start_s[2] = 1'b1;
    @(posedge clk); #1;
    chk("held_idle", 320'({valid_s[2], ready_s[2]}), 320'(2'b01));
    exp_q.push_back(ref_sub(b));
    @(posedge clk); #1;
    start_s[2] = 1'b0;
    st_in[2]   = ~b;
    wait_valid(2, n);
    finish_txn("held_b", 2, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_sub_layer.md
# ascon_sub_layer

Iterative, parametrised ASCON substitution layer. Applies the 5-bit ASCON S-box to all 64 columns of the 320-bit permutation state, NB_SBOX columns per clock cycle. Uses a start/valid handshake with an internal state register. Sits between the constant-addition and linear-diffusion stages of the permutation datapath, and replaces a fully unrolled 64-instance layer when area matters.

## Interface
Parameters:
- NB_SBOX, default 8: S-box instances, i.e. columns processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64; any other value fails an elaboration-time assertion. K = 64/NB_SBOX.

Ports:
- clock_i  in  1  rising-edge clock.
- resetb_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request. Sampled only while ready_o=1.
- state_i  in  type_state (5x64)  input state x0..x4. Captured on the edge that accepts start_i.
- ready_o  out  1  block idle, start accepted.
- valid_o  out  1  one-cycle pulse: state_o holds the completed result.
- state_o  out  type_state  internal state register; stable from valid_o until the next accepted start.

## Operation
- Column j is {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB (bit 4). The output column is written back into the same bit positions.
- S-box table, inputs 0x00..0x1F in order: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
- FSM states:
  - IDLE: ready_o=1. When start_i=1, load state_i, set cnt=0, go to RUN.
  - RUN: substitute columns cnt*NB_SBOX .. cnt*NB_SBOX+NB_SBOX-1 in place, then cnt++. When cnt=K-1 is written, go to DONE.
  - DONE: valid_o=1 for one cycle, then go to IDLE.
- cnt is clog2(K) bits wide, minimum 1 bit. Slice selection uses an indexed part-select. No wrap-around: cnt is cleared on every accepted start.
- start_i is ignored while in RUN or DONE. state_i changes after acceptance have no effect.
- Reset (any time, including mid-RUN): FSM=IDLE, cnt=0, state register=0, ready_o=1, valid_o=0, state_o=0. A partial result is discarded, with no valid_o.

## Timing
- Start sampled at edge E0. Slices are written at edges E1..EK. valid_o is high during the cycle after EK and ready_o returns after EK+1.
- Latency from acceptance to valid_o = K+1 cycles. Throughput is one state per K+2 cycles.
- NB_SBOX=64: K=1, so valid_o is high 2 cycles after acceptance.
- start_i asserted in the same cycle as valid_o is ignored. It is accepted in the following IDLE cycle.
- Combinational depth per cycle is one S-box plus a NB_SBOX-wide slice multiplexer.

## Configuration
- ASCON_SUB_PIPE_EN defined:
  - A register stage sits between the slice read and the write-back. Read slice cnt at Ei; write it back at Ei+1.
  - Writes occur at E2..EK+1.
  - Latency is K+2 cycles; valid_o is high after EK+1.
  - A 1-bit pipe-valid flag is added and is cleared by reset.
- ASCON_SUB_PIPE_EN undefined: behaviour exactly as in Operation/Timing, with no extra registers.

## Structure
- ascon_pack holds:
  - type_state (logic [0:4][63:0]),
  - the 32-entry S-box LUT constant,
  - the FSM enum type (IDLE/RUN/DONE).
- Sub-module: the existing 5-bit sbox cell, instantiated NB_SBOX times in a generate loop. No other hierarchy.

## Test plan
- NB_SBOX=8, state_i all zero, start -> valid_o after 9 cycles; state_o: x2=FFFFFFFFFFFFFFFF, x0=x1=x3=x4=0.
- NB_SBOX=8, state_i all ones -> x0=x2=x3=x4=FFFFFFFFFFFFFFFF, x1=0.
- NB_SBOX=1 and NB_SBOX=64, random state, all 32 column values covered -> state_o matches the bit-sliced reference model. valid_o arrives after 65 and 2 cycles respectively.
- Start re-asserted during RUN with a different state_i -> ignored; result corresponds to the first state, and exactly one valid_o pulse.
- resetb_i low at cycle 4 of RUN -> state_o=0, ready_o=1, no valid_o; a fresh start then completes normally.
- ASCON_SUB_PIPE_EN defined, NB_SBOX=8 -> same results as above, with valid_o after 10 cycles.
